planificador_bcd: RTL

Sequential binary-to-BCD conversion and display-scan controller for the microcontroller's 7-segment output peripheral. It accepts a byte from the core's peripheral write path and runs an 8-iteration shift-add-3 sequence on an internal shift register. It publishes the 12-bit BCD result (centenas, decenas, unidades) with a done pulse, then time-multiplexes the three digits onto a shared common-anode 7-segment bus.

---
 rtl/planificador_bcd_if.sv | 23 ++
 rtl/planificador_bcd.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/planificador_bcd_if.sv
// planificador_bcd_if: write path and display bus of the BCD peripheral.
// master drives writes; slave is the converter/scan block.
interface planificador_bcd_if;
  logic        we_i;
  logic [7:0]  dato_i;
  logic        ocupado_o;
  logic        listo_o;
  logic [11:0] decimal_o;
  logic [2:0]  anodos_o;
  logic [6:0]  segmentos_o;

  modport master (
    output we_i, dato_i,
    input  ocupado_o, listo_o, decimal_o,
    input  anodos_o, segmentos_o
  );

  modport slave (
    input  we_i, dato_i,
    output ocupado_o, listo_o, decimal_o,
    output anodos_o, segmentos_o
  );
endinterface

// File: rtl/planificador_bcd.sv
// planificador_bcd: byte to BCD (shift-add-3) plus 3-digit 7-seg scan.
// Optional leading-zero blanking: PLANIFICADOR_BCD_BLANK_CEROS_EN.
module planificador_bcd #(
  parameter int REFRESH_DIV = 50000
) (
  input logic clk,
  input logic rst,
  planificador_bcd_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int RW =
    (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] R_MAX = RW'(REFRESH_DIV - 1);

  logic [1:0]    st_q, st_d;
  logic [19:0]   sr_q, sr_adj;
  logic [2:0]    it_q;
  logic          pv_q;
  logic [7:0]    pd_q;
  logic          load;
  logic [7:0]    ld_val;
  logic [11:0]   dec_q;
  logic          listo_q, ocup_q;
  logic [RW-1:0] rc_q;
  logic [1:0]    idx_q, idx_n;
  logic [2:0]    an_q, an_n;
  logic [6:0]    sg_q, sg_n;
  logic [3:0]    nib;

  // Next state and load source; a write in DONE beats the pending byte.
  always_comb begin
    st_d   = st_q;
    load   = 1'b0;
    ld_val = bus.dato_i;
    unique case (st_q)
      S_IDLE: begin
        if (bus.we_i) begin
          load = 1'b1;
          st_d = S_CONV;
        end
      end
      S_CONV: begin
        if (it_q == 3'd7) st_d = S_DONE;
      end
      S_DONE: begin
        if (bus.we_i) begin
          load = 1'b1;
          st_d = S_CONV;
        end else if (pv_q) begin
          load   = 1'b1;
          ld_val = pd_q;
          st_d   = S_CONV;
        end else begin
          st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Add 3 to every BCD nibble that is 5 or more before the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[8+4*i +: 4] >= 4'd5)
        sr_adj[8+4*i +: 4] = sr_q[8+4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM, shift register, pending slot and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      sr_q    <= '0;
      it_q    <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      dec_q   <= '0;
      listo_q <= 1'b0;
      ocup_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      ocup_q  <= (st_d != S_IDLE);
      listo_q <= (st_q == S_DONE);
      if (st_q == S_DONE) dec_q <= sr_q[19:8];
      if (load) begin
        sr_q <= {12'b0, ld_val};
        it_q <= '0;
      end else if (st_q == S_CONV) begin
        sr_q <= {sr_adj[18:0], 1'b0};
        it_q <= it_q + 3'd1;
      end
      if (load) begin
        pv_q <= 1'b0;
      end else if (bus.we_i && st_q != S_IDLE) begin
        pv_q <= 1'b1;
        pd_q <= bus.dato_i;
      end
    end
  end

  // Digit, anode and segment pattern for the next scan slot.
  always_comb begin
    idx_n = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    nib   = dec_q[3:0];
    an_n  = 3'b110;
    unique case (1'b1)
      idx_n == 2'd1: begin
        nib  = dec_q[7:4];
        an_n = 3'b101;
      end
      idx_n == 2'd2: begin
        nib  = dec_q[11:8];
        an_n = 3'b011;
      end
      default: ;
    endcase
`ifdef PLANIFICADOR_BCD_BLANK_CEROS_EN
    if (idx_n == 2'd2 && dec_q[11:8] == 4'd0)
      an_n = 3'b111;
    if (idx_n == 2'd1 && dec_q[11:4] == 8'd0)
      an_n = 3'b111;
`endif
    case (nib)
      4'd0:    sg_n = 7'b1000000;
      4'd1:    sg_n = 7'b1111001;
      4'd2:    sg_n = 7'b0100100;
      4'd3:    sg_n = 7'b0110000;
      4'd4:    sg_n = 7'b0011001;
      4'd5:    sg_n = 7'b0010010;
      4'd6:    sg_n = 7'b0000010;
      4'd7:    sg_n = 7'b1111000;
      4'd8:    sg_n = 7'b0000000;
      4'd9:    sg_n = 7'b0010000;
      default: sg_n = 7'b1111111;
    endcase
  end

  // Free-running refresh counter; display registers change on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q  <= '0;
      idx_q <= '0;
      an_q  <= 3'b110;
      sg_q  <= 7'b1000000;
    end else if (rc_q == R_MAX) begin
      rc_q  <= '0;
      idx_q <= idx_n;
      an_q  <= an_n;
      sg_q  <= sg_n;
    end else begin
      rc_q <= rc_q + RW'(1);
    end
  end

  assign bus.ocupado_o   = ocup_q;
  assign bus.listo_o     = listo_q;
  assign bus.decimal_o   = dec_q;
  assign bus.anodos_o    = an_q;
  assign bus.segmentos_o = sg_q;
endmodule
